uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
- Parametrised successor to the 8051-style SFR UART. Memory-mapped full-duplex 8-bit UART on the same AB/DB/rd/wr peripheral bus.
- Adds: TX and RX FIFOs, a programmable 16-bit baud divisor with 16x oversampled receive, optional parity, 1 or 2 stop bits, loopback, sticky error flags and a maskable interrupt.

Parameters:
- BASE_ADDR, 8'h98: address of register offset 0; the block decodes BASE_ADDR..BASE_ADDR+4.
- FIFO_DEPTH, 16: entries per FIFO; power of 2, minimum 2.
- DIV_RESET, 16'd26: reset value of the baud divisor.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- AB  in  8  address bus
- DB  inout  8  data bus; driven only while rd==0 and address decoded, else 8'bz
- rd  in  1  read strobe, active-low
- wr  in  1  write strobe, active-low
- RxD  in  1  serial input (asynchronous)
- TxD  out  1  serial output, idle high
- Intuart  out  1  interrupt, active-high level

Behaviour:
- Registers (offset from BASE_ADDR):
  - 0 DATA: write pushes TX FIFO; read returns RX FIFO head (0x00 if empty).
  - 1 CTRL (RW): [0]TEN [1]REN [2]PEN [3]PODD [4]STOP2 [5]TXIE [6]RXIE [7]LOOP.
  - 2 STAT (RO): [0]rx_nonempty [1]rx_full [2]tx_empty [3]tx_full [4]tx_idle [5]OVR [6]PE [7]FE. Bits 5-7 are sticky; writing 1 clears the bit, writing 0 has no effect.
  - 3 DIVL, 4 DIVH: baud divisor.
- Reset (async, rst=1):
  - CTRL=0; DIV=DIV_RESET; FIFOs empty; stickies 0.
  - TX/RX FSMs idle; TxD=1; Intuart=0.
  - STAT therefore reads 0x14.
- Bus write:
  - Acts once per strobe, on the first clk edge where wr==0 (registered wr_q==1). DB is sampled at that edge.
  - wr held low for several cycles produces exactly one action.
- Bus read:
  - DB is combinational from AB.
  - DATA pop occurs on the first clk edge with rd==1 whose previous cycle had rd==0 and AB==BASE_ADDR.
  - Reading DATA when RX is empty does not pop.
- Baud tick:
  - 16-bit counter reloads to DIV and decrements; tick on reaching 0, so tick period = DIV+1 clocks.
  - Bit time = 16 ticks.
  - A DIV write takes effect at the next reload.
- TX FSM: IDLE -> START -> DATA(8, LSB first) -> PARITY (only if PEN) -> STOP (1 bit, or 2 if STOP2) -> IDLE.
  - Leaves IDLE on a tick when TEN==1 and TX FIFO is non-empty; pops the head in that cycle.
  - Parity bit = ^data ^ PODD (even parity when PODD=0).
  - Clearing TEN mid-frame completes the current frame, then holds in IDLE.
  - tx_idle=1 only in IDLE.
- RX path:
  - RxD (or internal TxD when LOOP=1) passes through a 2-FF synchroniser.
  - When LOOP=1, the TxD pin is held at 1.
- RX FSM: IDLE -> START -> DATA -> PARITY (if PEN) -> STOP -> IDLE. Entered on a synchronised falling edge while REN==1.
  - Each bit is sampled at tick 8 of its bit period.
  - Start bit sampled high: false start, return to IDLE with no push.
  - Parity mismatch sets PE.
  - Stop bit sampled 0 sets FE.
  - The byte is pushed even on PE/FE.
  - RX checks only the first stop bit; it re-arms for a new start immediately after it.
  - FIFO full at push: byte dropped, OVR set, FIFO contents unchanged.
  - Clearing REN mid-frame aborts to IDLE with no push.
- FIFO boundaries:
  - Push to a full TX FIFO is dropped silently.
  - Simultaneous push and pop on one FIFO leaves the count unchanged and order is preserved.
  - Counts are FIFO_DEPTH+1 states wide.
- Intuart (registered, one-cycle latency from state change) = (TXIE & tx_empty) | (RXIE & (rx_nonempty | OVR | PE | FE)).

Test Plan:
1. Reset mid-frame while TxD is low → TxD=1 asynchronously. Then read → STAT=0x14, CTRL=0x00, DIVL=26, DIVH=0. Intuart=0.
2. DIV=0, CTRL=0x01, write DATA=0xA5 → TxD: start 0 for 16 clks, bits 1,0,1,0,0,1,0,1 at 16 clks each, stop 1. Frame is 160 clks; tx_idle returns to 1.
3. CTRL=0x87 (LOOP|PEN|REN|TEN), write 0x3C → TxD pin stays 1 throughout. STAT bit0=1 after the frame; read DATA=0x3C; PE=0, FE=0.
4. REN=1, drive FIFO_DEPTH+1 frames 0x00..0x10 on RxD with no reads → rx_full=1, OVR=1. Reads return 0x00..0x0F in order. Write 0x20 to STAT → OVR=0.
5. Drive 0x55 with stop bit 0 → FE=1, DATA=0x55. With RXIE=1, Intuart=1 until FE is cleared and the FIFO is empty. Also drive a 4-clk low glitch → no push (false start).
6. TEN=0, write 17 bytes → tx_full after 16; 17th dropped. Set TEN=1, TXIE=1 → exactly 16 frames sent; Intuart rises one cycle after the last pop.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: memory-mapped full-duplex 8-bit UART with TX/RX FIFOs.
//
// Register map (offset from BASE_ADDR):
//   0 DATA  W: push TX FIFO   R: RX FIFO head (0x00 when empty), popped after the strobe
//   1 CTRL  [0]TEN [1]REN [2]PEN [3]PODD [4]STOP2 [5]TXIE [6]RXIE [7]LOOP
//   2 STAT  [0]rx_nonempty [1]rx_full [2]tx_empty [3]tx_full [4]tx_idle
//           [5]OVR [6]PE [7]FE  (bits 5-7 sticky, write 1 to clear)
//   3 DIVL, 4 DIVH: baud divisor, tick period = DIV+1 clocks, bit = 16 ticks
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   AB, DB       address bus, bidirectional data bus (driven only on a decoded read)
//   rd, wr       active-low read / write strobes
//   RxD, TxD     serial input (asynchronous), serial output (idle high)
//   Intuart      active-high level interrupt

module uart_fifo_buf #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign rdata = mem_q[rptr_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end
endmodule

module uart_fifo #(
  parameter logic [7:0]  BASE_ADDR  = 8'h98,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] AB,
  inout  wire  [7:0] DB,
  input  logic       rd,
  input  logic       wr,
  input  logic       RxD,
  output logic       TxD,
  output logic       Intuart
);
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  // Registers
  logic [7:0]  ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic        wr_q, wr_d;
  logic        data_rd_q, data_rd_d;
  logic        ovr_q, ovr_d, pe_q, pe_d, fe_q, fe_d;
  logic        int_q, int_d;

  tx_state_e   tx_state_q, tx_state_d;
  logic [3:0]  tx_tick_q, tx_tick_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_par_q, tx_par_d;

  rx_state_e   rx_state_q, rx_state_d;
  logic [3:0]  rx_tick_q, rx_tick_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;

  // Combinational
  logic [7:0]  offset, rdata, stat;
  logic        addr_hit, wr_fire, tick;
  logic        ten, ren, pen, podd, stop2, txie, rxie, loop;
  logic        tx_push, tx_pop, tx_empty, tx_full, tx_line;
  logic [7:0]  tx_head;
  logic        rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0]  rx_head;
  logic        set_ovr, set_pe, set_fe;
  logic        rx_mid, rx_end, tx_end;
  logic        rx_in;

  assign {loop, rxie, txie, stop2, podd, pen, ren, ten} = ctrl_q;

  // Modular offset keeps the decode correct even when the window wraps past 0xFF.
  assign offset   = AB - BASE_ADDR;
  assign addr_hit = (offset < 8'd5);
  assign wr_fire  = !wr && wr_q && addr_hit;
  assign rx_pop   = rd && data_rd_q;

  assign stat = {fe_q, pe_q, ovr_q, (tx_state_q == TX_IDLE), tx_full, tx_empty, rx_full, !rx_empty};

  always_comb begin
    rdata = '0;
    case (offset)
      8'd0:    rdata = rx_empty ? 8'h00 : rx_head;
      8'd1:    rdata = ctrl_q;
      8'd2:    rdata = stat;
      8'd3:    rdata = div_q[7:0];
      8'd4:    rdata = div_q[15:8];
      default: rdata = '0;
    endcase
  end

  assign DB = (!rd && addr_hit) ? rdata : 8'bz;

  // Bus writes and sticky flags
  always_comb begin
    ctrl_d    = ctrl_q;
    div_d     = div_q;
    tx_push   = 1'b0;
    wr_d      = wr;
    data_rd_d = !rd && (AB == BASE_ADDR);
    ovr_d     = ovr_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    if (wr_fire) begin
      case (offset)
        8'd0: tx_push = 1'b1;
        8'd1: ctrl_d = DB;
        8'd2: begin
          if (DB[5]) ovr_d = 1'b0;
          if (DB[6]) pe_d  = 1'b0;
          if (DB[7]) fe_d  = 1'b0;
        end
        8'd3: div_d[7:0]  = DB;
        8'd4: div_d[15:8] = DB;
        default: ;
      endcase
    end
    // A new error in the same cycle as a clear wins.
    if (set_ovr) ovr_d = 1'b1;
    if (set_pe)  pe_d  = 1'b1;
    if (set_fe)  fe_d  = 1'b1;
    int_d = (txie && tx_empty) || (rxie && (!rx_empty || ovr_q || pe_q || fe_q));
  end

  // Baud tick generator; a new divisor is picked up at the next reload.
  always_comb begin
    tick       = (baud_cnt_q == '0);
    baud_cnt_d = tick ? div_q : baud_cnt_q - 1'b1;
  end

  // TX FSM
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    tx_line    = 1'b1;
    tx_end     = tick && (tx_tick_q == 4'd15);
    if (tx_state_q != TX_IDLE && tick) tx_tick_d = tx_tick_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (tick && ten && !tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = TX_START;
          tx_tick_d  = '0;
          tx_bit_d   = '0;
          tx_shift_d = tx_head;
          tx_par_d   = (^tx_head) ^ podd;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_end) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_shift_q[0];
        if (tx_end) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_bit_d   = '0;
            tx_state_d = pen ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        tx_line = tx_par_q;
        if (tx_end) begin
          tx_bit_d   = '0;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_line = 1'b1;
        if (tx_end) begin
          if (stop2 && tx_bit_q == 3'd0) tx_bit_d = 3'd1;
          else                           tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign TxD = loop ? 1'b1 : tx_line;

  // RX FSM: samples mid-bit, leaves at mid first stop bit so the next start is caught.
  always_comb begin
    rx_in      = loop ? tx_line : RxD;
    rx_s1_d    = rx_in;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    set_ovr    = 1'b0;
    set_pe     = 1'b0;
    set_fe     = 1'b0;
    rx_mid     = tick && (rx_tick_q == 4'd7);
    rx_end     = tick && (rx_tick_q == 4'd15);
    if (rx_state_q != RX_IDLE && tick) rx_tick_d = rx_tick_q + 1'b1;
    case (rx_state_q)
      RX_IDLE: begin
        if (ren && rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_tick_d  = '0;
          rx_bit_d   = '0;
        end
      end
      RX_START: begin
        if (rx_mid && rx_s2_q) rx_state_d = RX_IDLE;
        else if (rx_end)       rx_state_d = RX_DATA;
      end
      RX_DATA: begin
        if (rx_mid) rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        if (rx_end) begin
          if (rx_bit_q == 3'd7) begin
            rx_bit_d   = '0;
            rx_state_d = pen ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_mid && (rx_s2_q != ((^rx_shift_q) ^ podd))) set_pe = 1'b1;
        if (rx_end) rx_state_d = RX_STOP;
      end
      RX_STOP: begin
        if (rx_mid) begin
          rx_push    = !rx_full;
          set_ovr    = rx_full;
          set_fe     = !rx_s2_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (!ren && rx_state_q != RX_IDLE) begin
      rx_state_d = RX_IDLE;
      rx_push    = 1'b0;
      set_ovr    = 1'b0;
      set_fe     = 1'b0;
      set_pe     = 1'b0;
    end
  end

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (DB),
    .pop   (tx_pop),
    .rdata (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  uart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_shift_q),
    .pop   (rx_pop),
    .rdata (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      div_q      <= DIV_RESET;
      baud_cnt_q <= DIV_RESET;
      wr_q       <= 1'b1;
      data_rd_q  <= 1'b0;
      ovr_q      <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      int_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      wr_q       <= wr_d;
      data_rd_q  <= data_rd_d;
      ovr_q      <= ovr_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      int_q      <= int_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
    end
  end

  assign Intuart = int_q;
endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] AB;
  wire  [7:0] DB;
  logic [7:0] tb_db;
  logic       tb_drv;
  logic       rd, wr, RxD;
  logic       TxD, Intuart;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] A_DATA = 8'h98;
  localparam logic [7:0] A_CTRL = 8'h99;
  localparam logic [7:0] A_STAT = 8'h9A;
  localparam logic [7:0] A_DIVL = 8'h9B;
  localparam logic [7:0] A_DIVH = 8'h9C;

  always #5 clk = ~clk;

  assign DB = tb_drv ? tb_db : 8'bz;

  uart_fifo #(.BASE_ADDR(8'h98), .FIFO_DEPTH(16), .DIV_RESET(16'd26)) dut (
    .clk     (clk),
    .rst     (rst),
    .AB      (AB),
    .DB      (DB),
    .rd      (rd),
    .wr      (wr),
    .RxD     (RxD),
    .TxD     (TxD),
    .Intuart (Intuart)
  );

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    AB = a; tb_db = d; tb_drv = 1'b1; wr = 1'b0;
    @(negedge clk);
    wr = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    AB = a; rd = 1'b0;
    #2 d = DB;
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
  endtask

  // Serial frame on RxD at 16 clocks per bit (DIV=0).
  task automatic send_rx(input logic [7:0] b, input logic has_par, input logic par, input logic stopb);
    @(negedge clk);
    RxD = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (16) @(negedge clk);
    end
    if (has_par) begin
      RxD = par;
      repeat (16) @(negedge clk);
    end
    RxD = stopb;
    repeat (16) @(negedge clk);
    RxD = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    int n;
    bus_write(A_DIVL, 8'h00);
    repeat (30) @(negedge clk);
    bus_write(A_CTRL, 8'h01);
    bus_write(A_DATA, 8'h00);
    n = 0;
    while (TxD !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (TxD !== 1'b0) begin errors++; $display("FAIL reset_pre_txd_low got %b want 0", TxD); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (TxD !== 1'b1) begin errors++; $display("FAIL reset_async_txd got %b want 1", TxD); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h14) begin errors++; $display("FAIL reset_stat got %h want 14", v); end
    bus_read(A_CTRL, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h want 00", v); end
    bus_read(A_DIVL, v);
    checks++;
    if (v !== 8'd26) begin errors++; $display("FAIL reset_divl got %h want 1a", v); end
    bus_read(A_DIVH, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_divh got %h want 00", v); end
    checks++;
    if (Intuart !== 1'b0) begin errors++; $display("FAIL reset_int got %b want 0", Intuart); end
  endtask

  task automatic test_tx_frame();
    logic [7:0] v;
    logic [7:0] exp_b;
    int n, len;
    exp_b = 8'hA5;
    bus_write(A_DIVL, 8'h00);
    repeat (30) @(negedge clk);
    bus_write(A_CTRL, 8'h01);
    bus_write(A_DATA, 8'hA5);
    n = 0;
    while (TxD !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (TxD !== 1'b0) begin errors++; $display("FAIL tx_start_timeout got %b want 0", TxD); end
    len = 0;
    while (TxD === 1'b0 && len < 40) begin len++; @(negedge clk); end
    checks++;
    if (len != 16) begin errors++; $display("FAIL tx_start_len got %0d want 16", len); end
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat (16) @(negedge clk);
      checks++;
      if (TxD !== exp_b[i]) begin errors++; $display("FAIL tx_bit%0d got %b want %b", i, TxD, exp_b[i]); end
    end
    repeat (16) @(negedge clk);
    checks++;
    if (TxD !== 1'b1) begin errors++; $display("FAIL tx_stop got %b want 1", TxD); end
    repeat (10) @(negedge clk);
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h14) begin errors++; $display("FAIL tx_done_stat got %h want 14", v); end
  endtask

  task automatic test_loopback();
    logic [7:0] v;
    int bad;
    bus_write(A_CTRL, 8'h87);
    bus_write(A_DATA, 8'h3C);
    bad = 0;
    repeat (220) begin
      @(negedge clk);
      if (TxD !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL loop_txd_pin got %0d low cycles want 0", bad); end
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h15) begin errors++; $display("FAIL loop_stat got %h want 15", v); end
    bus_read(A_DATA, v);
    checks++;
    if (v !== 8'h3C) begin errors++; $display("FAIL loop_data got %h want 3c", v); end
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h14) begin errors++; $display("FAIL loop_stat_after got %h want 14", v); end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] v;
    bus_write(A_CTRL, 8'h02);
    for (int i = 0; i < 17; i++) send_rx(8'(i), 1'b0, 1'b0, 1'b1);
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h37) begin errors++; $display("FAIL ovr_stat got %h want 37", v); end
    checks++;
    if (Intuart !== 1'b0) begin errors++; $display("FAIL ovr_int_masked got %b want 0", Intuart); end
    for (int i = 0; i < 16; i++) begin
      bus_read(A_DATA, v);
      checks++;
      if (v !== 8'(i)) begin errors++; $display("FAIL ovr_read%0d got %h want %h", i, v, 8'(i)); end
    end
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h34) begin errors++; $display("FAIL ovr_stat_drained got %h want 34", v); end
    bus_write(A_STAT, 8'h20);
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h14) begin errors++; $display("FAIL ovr_clear got %h want 14", v); end
  endtask

  task automatic test_rx_errors();
    logic [7:0] v;
    bus_write(A_CTRL, 8'h42);
    send_rx(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h95) begin errors++; $display("FAIL fe_stat got %h want 95", v); end
    checks++;
    if (Intuart !== 1'b1) begin errors++; $display("FAIL fe_int got %b want 1", Intuart); end
    bus_read(A_DATA, v);
    checks++;
    if (v !== 8'h55) begin errors++; $display("FAIL fe_data got %h want 55", v); end
    repeat (2) @(negedge clk);
    checks++;
    if (Intuart !== 1'b1) begin errors++; $display("FAIL fe_int_held got %b want 1", Intuart); end
    bus_write(A_STAT, 8'h80);
    repeat (2) @(negedge clk);
    checks++;
    if (Intuart !== 1'b0) begin errors++; $display("FAIL fe_int_cleared got %b want 0", Intuart); end
    // 4-clock glitch must be rejected as a false start
    @(negedge clk);
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    RxD = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h14) begin errors++; $display("FAIL glitch_stat got %h want 14", v); end
    // even parity: 0x01 needs parity 1, send 0
    bus_write(A_CTRL, 8'h06);
    send_rx(8'h01, 1'b1, 1'b0, 1'b1);
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h55) begin errors++; $display("FAIL pe_stat got %h want 55", v); end
    bus_read(A_DATA, v);
    checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL pe_data got %h want 01", v); end
    bus_write(A_STAT, 8'h40);
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h14) begin errors++; $display("FAIL pe_clear got %h want 14", v); end
  endtask

  task automatic test_tx_burst();
    logic [7:0] v;
    int frames, n;
    bus_write(A_CTRL, 8'h00);
    for (int i = 0; i < 16; i++) bus_write(A_DATA, 8'(8'h40 + i));
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h18) begin errors++; $display("FAIL burst_full_stat got %h want 18", v); end
    bus_write(A_DATA, 8'h99);
    bus_write(A_CTRL, 8'h21);
    checks++;
    if (Intuart !== 1'b0) begin errors++; $display("FAIL burst_int_start got %b want 0", Intuart); end
    frames = 0;
    for (int f = 0; f < 20; f++) begin
      n = 0;
      while (TxD !== 1'b0 && n < 400) begin @(negedge clk); n++; end
      if (TxD !== 1'b0) break;
      frames++;
      if (frames == 16) begin
        checks++;
        if (Intuart !== 1'b0) begin errors++; $display("FAIL burst_int_at_pop got %b want 0", Intuart); end
        @(negedge clk);
        checks++;
        if (Intuart !== 1'b1) begin errors++; $display("FAIL burst_int_after_pop got %b want 1", Intuart); end
        repeat (157) @(negedge clk);
      end else begin
        repeat (158) @(negedge clk);
      end
    end
    checks++;
    if (frames != 16) begin errors++; $display("FAIL burst_frames got %0d want 16", frames); end
    bus_read(A_STAT, v);
    checks++;
    if (v !== 8'h14) begin errors++; $display("FAIL burst_end_stat got %h want 14", v); end
  endtask

  initial begin
    rst = 1'b1; AB = 8'h00; tb_db = 8'h00; tb_drv = 1'b0;
    rd = 1'b1; wr = 1'b1; RxD = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_tx_frame();
    test_loopback();
    test_rx_overflow();
    test_rx_errors();
    test_tx_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
